// File: rtl/freq_gen_pkg.sv
// Shared constants and helpers for the programmable square-wave source.
package freq_gen_pkg;

  // Default input clock frequency in Hz.
  localparam int CLK_HZ_DEF = 50000000;

  // Largest legal value of one BCD digit.
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Digit slots in the shadow register file.
  localparam logic [1:0] DIG_UNITS    = 2'd0;
  localparam logic [1:0] DIG_TENS     = 2'd1;
  localparam logic [1:0] DIG_HUNDREDS = 2'd2;

  // Three BCD digits give 0..999 Hz.
  localparam int NUM_DIGITS = 3;
  localparam int FREQ_MAX   = 999;
  localparam int FREQ_W     = $clog2(FREQ_MAX + 1);

  typedef logic [3:0] bcd_t;

  // A write is accepted only for an existing slot and a decimal digit.
  function automatic logic bcd_write_ok(input logic [1:0] sel, input bcd_t val);
    return (sel <= DIG_HUNDREDS) && (val <= BCD_MAX);
  endfunction

endpackage

// File: rtl/freq_gen_bcd3_to_bin.sv
// Combinational conversion of three BCD digits into binary using shifts
// and adds only (100x = 64x + 32x + 4x, 10x = 8x + 2x).
module bcd3_to_bin
  import freq_gen_pkg::*;
(
  input  logic [3:0]        d_hundreds,
  input  logic [3:0]        d_tens,
  input  logic [3:0]        d_units,
  output logic [FREQ_W-1:0] bin
);

  logic [FREQ_W-1:0] h_ext;
  logic [FREQ_W-1:0] t_ext;
  logic [FREQ_W-1:0] u_ext;

  // Zero-extend each digit to the result width before shifting.
  always_comb begin
    h_ext = {{(FREQ_W-4){1'b0}}, d_hundreds};
    t_ext = {{(FREQ_W-4){1'b0}}, d_tens};
    u_ext = {{(FREQ_W-4){1'b0}}, d_units};
  end

  // Weighted sum; legal digits keep the result within 0..999.
  always_comb begin
    bin = (h_ext << 6) + (h_ext << 5) + (h_ext << 2)
        + (t_ext << 3) + (t_ext << 1)
        + u_ext;
  end

endmodule

// File: rtl/freq_gen.sv
// Programmable 0..999 Hz square-wave source with an exact edge count per
// second, plus a free-running one-second tick for aligning gate windows.
//
// Host interface: wr and commit are single-cycle strobes with no ready
// side; the block accepts every strobe on the clock edge where it is high.
// A commit applies the shadow digits as they were before that edge, so a
// write in the same cycle lands in the shadow for the next commit.
module freq_gen
  import freq_gen_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEF,
  parameter int ACC_W  = 27,
  parameter int SEC_W  = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [1:0]       digit_sel,
  input  logic [3:0]       bcd_in,
  input  logic             commit,
  output logic             wave_out,
  output logic [9:0]       freq_bin,
  output logic             active,
  output logic             sec_tick,
  output logic             err
);

  localparam logic [ACC_W-1:0] ACC_LIM  = ACC_W'(CLK_HZ);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(CLK_HZ - 1);
  localparam logic [SEC_W-1:0] SEC_PRE  = SEC_W'(CLK_HZ - 2);

  bcd_t              shadow_units;
  bcd_t              shadow_tens;
  bcd_t              shadow_hundreds;
  logic              write_ok;
  logic [FREQ_W-1:0] conv_bin;

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_step;
  logic [ACC_W-1:0]  acc_sum;
  logic              acc_wrap;
  logic              run;

  logic [SEC_W-1:0]  sec_cnt;

  // Decode whether the current write request is legal.
  always_comb begin
    write_ok = bcd_write_ok(digit_sel, bcd_in);
  end

  // Shadow digit registers; illegal writes leave them untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_units    <= '0;
      shadow_tens     <= '0;
      shadow_hundreds <= '0;
    end else if (wr && write_ok) begin
      case (digit_sel)
        DIG_UNITS:    shadow_units    <= bcd_in;
        DIG_TENS:     shadow_tens     <= bcd_in;
        DIG_HUNDREDS: shadow_hundreds <= bcd_in;
        default:      ;
      endcase
    end
  end

  // Sticky error flag for any rejected write; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (wr && !write_ok) begin
      err <= 1'b1;
    end
  end

  bcd3_to_bin u_bcd3_to_bin (
    .d_hundreds (shadow_hundreds),
    .d_tens     (shadow_tens),
    .d_units    (shadow_units),
    .bin        (conv_bin)
  );

  // Register the converted frequency and its non-zero flag on commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_bin <= '0;
      active   <= 1'b0;
    end else if (commit) begin
      freq_bin <= conv_bin;
      active   <= (conv_bin != '0);
    end
  end

  // Phase step is twice the frequency: one toggle per half period.
  always_comb begin
    run      = (freq_bin != '0);
    acc_step = ACC_W'({freq_bin, 1'b0});
    acc_sum  = acc + acc_step;
    acc_wrap = (acc_sum >= ACC_LIM);
  end

  // Phase accumulator and wave output. The accumulator is never cleared by
  // a re-commit, so rate changes are phase-continuous and glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      wave_out <= 1'b0;
    end else if (!run) begin
      acc      <= '0;
      wave_out <= 1'b0;
    end else if (acc_wrap) begin
      acc      <= acc_sum - ACC_LIM;
      wave_out <= ~wave_out;
    end else begin
      acc      <= acc_sum;
    end
  end

  // Free-running 0..CLK_HZ-1 counter; the tick is registered one count
  // early so it is high exactly while the counter reads CLK_HZ-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_cnt  <= '0;
      sec_tick <= 1'b0;
    end else begin
      if (sec_cnt == SEC_LAST) begin
        sec_cnt <= '0;
      end else begin
        sec_cnt <= sec_cnt + SEC_W'(1);
      end
      sec_tick <= (sec_cnt == SEC_PRE);
    end
  end

endmodule

// File: tb/tb_freq_gen.sv
// Directed bench for freq_gen with a commit-result scoreboard.
module tb_freq_gen;

  localparam int CLK_HZ = 10000;
  localparam int ACC_W  = 15;
  localparam int SEC_W  = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic [1:0] digit_sel = 2'd0;
  logic [3:0] bcd_in = 4'd0;
  logic       commit = 1'b0;
  logic       wave_out;
  logic [9:0] freq_bin;
  logic       active;
  logic       sec_tick;
  logic       err;

  int n_vec = 0;
  int n_bad = 0;

  logic [10:0] exp_q[$];
  logic        cmt_d = 1'b0;
  logic [10:0] mon_exp;
  logic [10:0] mon_got;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  freq_gen #(
    .CLK_HZ (CLK_HZ),
    .ACC_W  (ACC_W),
    .SEC_W  (SEC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr        (wr),
    .digit_sel (digit_sel),
    .bcd_in    (bcd_in),
    .commit    (commit),
    .wave_out  (wave_out),
    .freq_bin  (freq_bin),
    .active    (active),
    .sec_tick  (sec_tick),
    .err       (err)
  );

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk or posedge rst) begin
    if (rst) cmt_d <= 1'b0;
    else     cmt_d <= commit;
  end

  always @(negedge clk) begin
    if (cmt_d) begin
      mon_got = {active, freq_bin};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL commit_result: got active=%0d freq=%0d, nothing expected",
                 mon_got[10], mon_got[9:0]);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_bad++;
          $display("FAIL commit_result: got active=%0d freq=%0d, want active=%0d freq=%0d",
                   mon_got[10], mon_got[9:0], mon_exp[10], mon_exp[9:0]);
        end
      end
    end
  end

  // ---------------- check helpers ----------------
  task automatic check_eq(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, expv);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [1:0] sel, input logic [3:0] val);
    @(negedge clk);
    wr = 1'b1; digit_sel = sel; bcd_in = val;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic do_commit(input logic exp_act, input int exp_freq);
    exp_q.push_back({exp_act, 10'(exp_freq)});
    @(negedge clk);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  // Cycles until wave_out changes level; -1 on timeout.
  task automatic wait_toggle(input int max_cyc, output int cyc);
    logic start;
    start = wave_out;
    cyc = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (wave_out !== start) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Wait for a fresh 0->1 transition of wave_out.
  task automatic wait_rise(input int max_cyc, output logic ok);
    logic prev;
    prev = wave_out;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (wave_out === 1'b1 && prev === 1'b0) begin
        ok = 1'b1;
        break;
      end
      prev = wave_out;
    end
  endtask

  task automatic count_rises(input int ncyc, output int rises);
    logic prev;
    prev = wave_out;
    rises = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (wave_out === 1'b1 && prev === 1'b0) rises++;
      prev = wave_out;
    end
  endtask

  // Cycles until sec_tick is seen high; -1 on timeout.
  task automatic wait_tick(input int max_cyc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (sec_tick === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   c;
    int   r;
    logic ok;
    logic lvl;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_wave", int'(wave_out), 0);
    check_eq("rst_freq", int'(freq_bin), 0);
    check_eq("rst_active", int'(active), 0);
    check_eq("rst_tick", int'(sec_tick), 0);
    check_eq("rst_err", int'(err), 0);
    rst = 1'b0;

    // 50 Hz: toggle every 100 cycles, 50 rises per 10000 cycles
    do_write(2'd0, 4'd0);
    do_write(2'd1, 4'd5);
    do_write(2'd2, 4'd0);
    do_commit(1'b1, 50);
    wait_toggle(300, c);
    check_eq("first_toggle_50", c, 100);
    wait_toggle(300, c);
    check_eq("period_50", c, 100);
    count_rises(10000, r);
    check_eq("rises_50", r, 50);

    // 7 Hz: toggle every 714/715 cycles, 7 rises per tick window
    do_write(2'd1, 4'd0);
    do_write(2'd0, 4'd7);
    do_commit(1'b1, 7);
    wait_toggle(2000, c);
    check_rng("first_toggle_7", c, 1, 715);
    wait_toggle(2000, c);
    check_rng("period_7a", c, 714, 715);
    wait_toggle(2000, c);
    check_rng("period_7b", c, 714, 715);
    wait_tick(12000, c);
    check_rng("tick_seen", c, 1, 10000);
    begin
      logic prev;
      prev = wave_out;
      r = 0;
      c = -1;
      for (int i = 1; i <= 12000; i++) begin
        @(negedge clk);
        if (wave_out === 1'b1 && prev === 1'b0) r++;
        prev = wave_out;
        if (sec_tick === 1'b1) begin
          c = i;
          break;
        end
      end
    end
    check_eq("tick_spacing", c, 10000);
    check_eq("rises_7_window", r, 7);
    @(negedge clk);
    check_eq("tick_width", int'(sec_tick), 0);

    // Rejected writes: err sticky, shadow unchanged
    check_eq("err_before", int'(err), 0);
    do_write(2'd0, 4'd12);
    check_eq("err_bad_bcd", int'(err), 1);
    do_write(2'd3, 4'd4);
    do_commit(1'b1, 7);
    repeat (5) @(negedge clk);
    check_eq("err_sticky", int'(err), 1);

    // Reset clears err and shadow; write and commit in the same cycle
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("err_cleared", int'(err), 0);
    exp_q.push_back({1'b0, 10'd0});
    @(negedge clk);
    wr = 1'b1; digit_sel = 2'd0; bcd_in = 4'd9; commit = 1'b1;
    @(negedge clk);
    wr = 1'b0; commit = 1'b0;
    @(negedge clk);
    check_eq("same_cycle_wave", int'(wave_out), 0);
    do_commit(1'b1, 9);

    // Re-commit while running: level kept, new rate exact
    do_write(2'd0, 4'd0);
    do_write(2'd1, 4'd5);
    do_commit(1'b1, 50);
    wait_toggle(2000, c);
    check_rng("toggle_after_50", c, 1, 2000);
    do_write(2'd2, 4'd1);
    do_write(2'd1, 4'd0);
    lvl = wave_out;
    do_commit(1'b1, 100);
    check_eq("level_kept", int'(wave_out), int'(lvl));
    count_rises(10000, r);
    check_eq("rises_100", r, 100);

    // Commit 0 while high: forced low within 2 cycles
    do_write(2'd2, 4'd0);
    wait_rise(200, ok);
    check_eq("rise_before_stop", int'(ok), 1);
    do_commit(1'b0, 0);
    @(negedge clk);
    check_eq("stop_wave", int'(wave_out), 0);
    repeat (300) @(negedge clk);
    check_eq("stop_wave_hold", int'(wave_out), 0);

    // Reset mid-wave with wave_out high
    do_write(2'd1, 4'd5);
    do_commit(1'b1, 50);
    wait_rise(300, ok);
    check_eq("rise_before_rst", int'(ok), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_wave", int'(wave_out), 0);
    check_eq("midrst_freq", int'(freq_bin), 0);
    check_eq("midrst_active", int'(active), 0);
    check_eq("midrst_tick", int'(sec_tick), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_tick(12000, c);
    check_eq("first_tick_after_rst", c, 9999);
    @(negedge clk);
    check_eq("tick_width_rst", int'(sec_tick), 0);
    check_eq("wave_idle_after_rst", int'(wave_out), 0);

    repeat (3) @(negedge clk);
    check_eq("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
